// File: rtl/lab3_probe.sv
// lab3_probe: sequences the four input vectors {in1,in2} = 0..3 into a
// two-input gate network, waits for its output to settle on each vector,
// and records the settled response, the worst settle time and a timeout flag.
module lab3_probe #(
    parameter int STABLE_N   = 2,
    parameter int SETTLE_MAX = 15,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic             drv_in1,
    output logic             drv_in2,
    output logic             busy,
    output logic             done,
    output logic [3:0]       result,
    output logic [CNT_W-1:0] settle_max,
    output logic             timeout
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_N);
    localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(SETTLE_MAX);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [1:0]       v_reg, v_next;
    logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0] stab_cnt_reg, stab_cnt_next;
    logic             prev_reg, prev_next;
    logic             drv1_reg, drv1_next;
    logic             drv2_reg, drv2_next;
    logic             done_reg, done_next;
    logic [3:0]       result_reg, result_next;
    logic [CNT_W-1:0] smax_reg, smax_next;
    logic             timeout_reg, timeout_next;

    // Saturating increments used while waiting for the network to settle
    logic [CNT_W-1:0] wait_inc;
    logic [CNT_W-1:0] stab_inc;

    // One-hot select of the result bit owned by the current vector
    logic [3:0] vec_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_vec_sel
            assign vec_sel[gi] = (v_reg == 2'(gi));
        end
    endgenerate

    // Saturating counter arithmetic; the wait counter never passes the limit
    // and the stability counter never passes the settled threshold
    always_comb begin
        wait_inc = (wait_cnt_reg == LIMIT_C) ? wait_cnt_reg : wait_cnt_reg + ONE_C;
        if (dut_out == prev_reg) begin
            stab_inc = (stab_cnt_reg == STABLE_C) ? stab_cnt_reg : stab_cnt_reg + ONE_C;
        end else begin
            stab_inc = '0;
        end
    end

    // State and datapath registers; reset takes effect without a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            v_reg        <= 2'd0;
            wait_cnt_reg <= '0;
            stab_cnt_reg <= '0;
            prev_reg     <= 1'b0;
            drv1_reg     <= 1'b0;
            drv2_reg     <= 1'b0;
            done_reg     <= 1'b0;
            result_reg   <= 4'd0;
            smax_reg     <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            v_reg        <= v_next;
            wait_cnt_reg <= wait_cnt_next;
            stab_cnt_reg <= stab_cnt_next;
            prev_reg     <= prev_next;
            drv1_reg     <= drv1_next;
            drv2_reg     <= drv2_next;
            done_reg     <= done_next;
            result_reg   <= result_next;
            smax_reg     <= smax_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Next-state and datapath updates for the probe sequence
    always_comb begin
        state_next    = state_reg;
        v_next        = v_reg;
        wait_cnt_next = wait_cnt_reg;
        stab_cnt_next = stab_cnt_reg;
        prev_next     = prev_reg;
        drv1_next     = drv1_reg;
        drv2_next     = drv2_reg;
        done_next     = 1'b0;
        result_next   = result_reg;
        smax_next     = smax_reg;
        timeout_next  = timeout_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = APPLY;
                    v_next       = 2'd0;
                    drv1_next    = 1'b0;
                    drv2_next    = 1'b0;
                    result_next  = 4'd0;
                    smax_next    = '0;
                    timeout_next = 1'b0;
                end
            end
            APPLY: begin
                wait_cnt_next = '0;
                stab_cnt_next = '0;
                prev_next     = dut_out;
                state_next    = WAIT;
            end
            WAIT: begin
                wait_cnt_next = wait_inc;
                stab_cnt_next = stab_inc;
                prev_next     = dut_out;
                // Settling wins over the limit when both happen on one cycle;
                // on a timeout the wait counter already holds the limit value
                if (stab_inc == STABLE_C) begin
                    state_next = CAPTURE;
                end else if (wait_inc == LIMIT_C) begin
                    timeout_next = 1'b1;
                    state_next   = CAPTURE;
                end
            end
            CAPTURE: begin
                result_next = (result_reg & ~vec_sel) | (vec_sel & {4{dut_out}});
                smax_next   = (wait_cnt_reg > smax_reg) ? wait_cnt_reg : smax_reg;
                if (v_reg != 2'd3) begin
                    v_next     = v_reg + 2'd1;
                    drv1_next  = v_next[1];
                    drv2_next  = v_next[0];
                    state_next = APPLY;
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Busy covers the vector-driving states only
    assign busy       = (state_reg == APPLY) || (state_reg == WAIT) || (state_reg == CAPTURE);
    assign drv_in1    = drv1_reg;
    assign drv_in2    = drv2_reg;
    assign done       = done_reg;
    assign result     = result_reg;
    assign settle_max = smax_reg;
    assign timeout    = timeout_reg;

endmodule

// File: tb/tb_lab3_probe.sv
// tb_lab3_probe: directed and randomized probe runs against lab3_probe,
// with a window-based reference model for sequence-driven dut_out.
module tb_lab3_probe;

    localparam int STABLE_N   = 2;
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = 4;
    localparam int SEQ_LEN    = 256;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             dut_out;
    logic             drv_in1;
    logic             drv_in2;
    logic             busy;
    logic             done;
    logic [3:0]       result;
    logic [CNT_W-1:0] settle_max;
    logic             timeout;

    int checks = 0;
    int passed = 0;

    // Stimulus sources for dut_out: 0 = bit sequence, 1 = XOR gate, 2 = slow glitchy XOR
    int   mode = 0;
    bit   seq [SEQ_LEN];
    logic seq_bit = 1'b0;
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic [1:0] dd1 = 2'b00, dd2 = 2'b00;

    lab3_probe #(
        .STABLE_N  (STABLE_N),
        .SETTLE_MAX(SETTLE_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dut_out   (dut_out),
        .drv_in1   (drv_in1),
        .drv_in2   (drv_in2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .settle_max(settle_max),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Delayed network: output follows the XOR three cycles late and glitches
    // for one cycle right after the drivers change
    always @(posedge clk) begin
        s1  <= drv_in1 ^ drv_in2;
        s2  <= s1;
        s3  <= s2;
        dd1 <= {drv_in1, drv_in2};
        dd2 <= dd1;
    end

    always_comb begin
        dut_out = seq_bit;
        case (mode)
            0:       dut_out = seq_bit;
            1:       dut_out = drv_in1 ^ drv_in2;
            default: dut_out = s3 ^ (dd1 != dd2);
        endcase
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Reference: a vector settles at the first WAIT step k where the samples
    // from k-STABLE_N to k after APPLY are all equal; otherwise it times out.
    // Sample index n is the dut_out value seen at the n-th edge after start.
    task automatic model(output logic [3:0] res, output int smax, output bit to, output int lat);
        int a;
        a    = 1;
        res  = 4'd0;
        smax = 0;
        to   = 1'b0;
        for (int v = 0; v < 4; v++) begin
            int  settle;
            bit  found;
            settle = SETTLE_MAX;
            found  = 1'b0;
            for (int k = STABLE_N; k <= SETTLE_MAX; k++) begin
                if (!found) begin
                    bit same;
                    same = 1'b1;
                    for (int j = a + k - STABLE_N; j <= a + k; j++)
                        if (seq[j] != seq[a + k]) same = 1'b0;
                    if (same) begin
                        settle = k;
                        found  = 1'b1;
                    end
                end
            end
            if (!found) to = 1'b1;
            res[v] = seq[a + settle + 1];
            if (settle > smax) smax = settle;
            a = a + settle + 2;
        end
        lat = a;
    endtask

    // One probe run from IDLE; optional start pokes land in WAIT and in DONE
    task automatic run(input string tag, input logic [3:0] exp_res, input int exp_smax,
                       input bit exp_to, input int exp_lat, input bit poke);
        int k, done_at, done_cnt, busy_at_done, busy_after;
        start   = 1'b1;
        seq_bit = seq[0];
        @(posedge clk);
        k = 0;
        #1;
        start   = 1'b0;
        seq_bit = seq[1];
        @(negedge clk);
        check({tag, "/busy_on_start"}, int'(busy), 1);
        done_at      = -1;
        done_cnt     = 0;
        busy_at_done = -1;
        busy_after   = -1;
        while (k < 200) begin
            @(posedge clk);
            k++;
            #1;
            if (poke) start = (k == 5) || (k == exp_lat - 1);
            seq_bit = seq[(k + 1 < SEQ_LEN) ? k + 1 : SEQ_LEN - 1];
            @(negedge clk);
            if (done_at >= 0 && k == done_at + 1) busy_after = int'(busy);
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at      = k;
                    busy_at_done = int'(busy);
                end
            end
            if (done_at >= 0 && k >= done_at + 6) break;
        end
        start = 1'b0;
        $display("run %s: result=%b settle_max=%0d timeout=%0d done_at=%0d done_pulses=%0d",
                 tag, result, settle_max, timeout, done_at, done_cnt);
        check({tag, "/latency"},      done_at,        exp_lat);
        check({tag, "/done_pulses"},  done_cnt,       1);
        check({tag, "/busy_at_done"}, busy_at_done,   0);
        check({tag, "/busy_after"},   busy_after,     0);
        check({tag, "/result"},       int'(result),   int'(exp_res));
        check({tag, "/settle_max"},   int'(settle_max), exp_smax);
        check({tag, "/timeout"},      int'(timeout),  int'(exp_to));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/drv_in1"},    int'(drv_in1),    0);
        check({tag, "/drv_in2"},    int'(drv_in2),    0);
        check({tag, "/busy"},       int'(busy),       0);
        check({tag, "/done"},       int'(done),       0);
        check({tag, "/result"},     int'(result),     0);
        check({tag, "/settle_max"}, int'(settle_max), 0);
        check({tag, "/timeout"},    int'(timeout),    0);
    endtask

    initial begin
        logic [3:0] m_res;
        int         m_smax, m_lat, waited;
        bit         m_to;

        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 1'b0;
        #2;
        check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a run (XOR network, during vector 2)
        mode  = 1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waited = 0;
        while (!drv_in1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("midrun/reached_v2", int'(drv_in1), 1);
        @(negedge clk);
        @(negedge clk);
        check("midrun/partial_result", int'(result), 4'b0010);
        check("midrun/busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        $display("run midrun_reset: result=%b settle_max=%0d busy=%0d", result, settle_max, busy);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Constant 1, with start pokes during WAIT and DONE
        mode = 0;
        for (int i = 0; i < SEQ_LEN; i++) seq[i] = 1'b1;
        run("const1", 4'b1111, 2, 1'b0, 17, 1'b1);

        // Combinational XOR network
        mode = 1;
        run("xor", 4'b0110, 2, 1'b0, 17, 1'b0);

        // Output toggling every cycle never settles
        mode = 0;
        for (int i = 0; i < SEQ_LEN; i++) seq[i] = i[0];
        model(m_res, m_smax, m_to, m_lat);
        run("toggle", m_res, 15, 1'b1, 69, 1'b0);

        // Slow XOR with glitch; drivers go 11 -> 00 at start so vector 0 also glitches
        mode = 2;
        run("delayed", 4'b0110, 5, 1'b0, 27, 1'b0);

        // Randomized output sequences with varying toggle density
        mode = 0;
        for (int r = 0; r < 8; r++) begin
            int  p;
            bit  cur;
            p   = $urandom_range(0, 4);
            cur = 1'($urandom_range(0, 1));
            for (int i = 0; i < SEQ_LEN; i++) begin
                if ($urandom_range(0, 7) < p) cur = ~cur;
                seq[i] = cur;
            end
            model(m_res, m_smax, m_to, m_lat);
            run($sformatf("rand%0d", r), m_res, m_smax, m_to, m_lat, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
